// File: rtl/ds1302_time_set.sv
// ---------------------------------------------------------------------------
// ds1302_time_set
//
// Time-set sequencer for the DS1302 RTC path. On a start pulse it range-checks
// a binary hh:mm:ss triple, converts each field to BCD and walks an ordered
// table of single-byte register writes through the downstream 1-byte write
// engine (en/addr/dataIn/done handshake).
//
// Build option:
//   DS1302_WP_EN  defined   -> 5 writes: clear WP, sec, min, hour, set WP
//                 undefined -> 3 writes: sec, min, hour (caller owns WP)
//
// Parameters:
//   TIMEOUT_CYCLES  max clk cycles to wait for wrDone per write
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   start   in   one-cycle request, sampled only while idle
//   secIn   in   [5:0] seconds, binary 0..59
//   minIn   in   [5:0] minutes, binary 0..59
//   hourIn  in   [4:0] hours, binary 0..23 (24 h)
//   wrEn    out  one-cycle write request to the write engine
//   wrAddr  out  [7:0] DS1302 write command byte
//   wrData  out  [7:0] byte to write
//   wrDone  in   one-cycle completion pulse from the write engine
//   busy    out  high while a sequence is in flight
//   done    out  one-cycle pulse when all writes completed
//   err     out  one-cycle pulse on range reject or timeout
// ---------------------------------------------------------------------------
module ds1302_time_set #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] secIn,
  input  logic [5:0] minIn,
  input  logic [4:0] hourIn,
  output logic       wrEn,
  output logic [7:0] wrAddr,
  output logic [7:0] wrData,
  input  logic       wrDone,
  output logic       busy,
  output logic       done,
  output logic       err
);

`ifdef DS1302_WP_EN
  localparam int NUM_STEPS = 5;
`else
  localparam int NUM_STEPS = 3;
`endif

  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t           state;
  logic [2:0]       step;
  logic [CNT_W-1:0] toCnt;

  // BCD copies of the accepted request; frozen for the whole sequence.
  logic [7:0] secBcd;
  logic [7:0] minBcd;
  logic [7:0] hourBcd;

  // Binary to packed BCD by repeated compare-subtract (inputs are < 64, so at
  // most six subtractions). Top nibble is the tens digit.
  function automatic logic [7:0] toBcd(input logic [5:0] v);
    logic [5:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // Write table: {command byte, data byte} for a given step index.
  // In range, seconds tens <= 5 keeps CH (bit 7) clear, and hours tens <= 2
  // keeps bit 7 clear (24 h mode) with the tens digit in bits 5:4.
  function automatic logic [15:0] stepWord(input logic [2:0] idx,
                                           input logic [7:0] s,
                                           input logic [7:0] m,
                                           input logic [7:0] h);
    logic [15:0] w;
`ifdef DS1302_WP_EN
    case (idx)
      3'd0:    w = {8'h8E, 8'h00};
      3'd1:    w = {8'h80, s};
      3'd2:    w = {8'h82, m};
      3'd3:    w = {8'h84, h};
      default: w = {8'h8E, 8'h80};
    endcase
`else
    case (idx)
      3'd0:    w = {8'h80, s};
      3'd1:    w = {8'h82, m};
      default: w = {8'h84, h};
    endcase
`endif
    return w;
  endfunction

  logic       fieldsOk;
  logic [7:0] secBcdIn;
  logic [7:0] minBcdIn;
  logic [7:0] hourBcdIn;

  assign fieldsOk  = (secIn <= 6'd59) && (minIn <= 6'd59) && (hourIn <= 5'd23);
  assign secBcdIn  = toBcd(secIn);
  assign minBcdIn  = toBcd(minIn);
  assign hourBcdIn = toBcd({1'b0, hourIn});

  // Request capture: data path only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && fieldsOk) begin
      secBcd  <= secBcdIn;
      minBcd  <= minBcdIn;
      hourBcd <= hourBcdIn;
    end
  end

  // Sequencer. The first write is launched straight from IDLE using the
  // freshly converted inputs so wrEn appears the cycle after start; later
  // writes are launched from WAIT on wrDone so the next wrEn follows wrDone
  // by one cycle. ISSUE is the single wrEn cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      step   <= 3'd0;
      toCnt  <= '0;
      wrEn   <= 1'b0;
      wrAddr <= 8'h00;
      wrData <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      wrEn <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            if (fieldsOk) begin
              step             <= 3'd0;
              wrEn             <= 1'b1;
              busy             <= 1'b1;
              {wrAddr, wrData} <= stepWord(3'd0, secBcdIn, minBcdIn, hourBcdIn);
              state            <= ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ISSUE: begin
          toCnt <= '0;
          state <= WAIT;
        end

        WAIT: begin
          // wrDone takes priority over a timeout in the same cycle.
          if (wrDone) begin
            if (step == LAST_STEP) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              step             <= step + 3'd1;
              wrEn             <= 1'b1;
              {wrAddr, wrData} <= stepWord(step + 3'd1, secBcd, minBcd, hourBcd);
              state            <= ISSUE;
            end
          end else if (toCnt == CNT_LIMIT) begin
            // Abort: remaining steps are dropped. FINISH only drops busy
            // here, err replaces the done pulse.
            err   <= 1'b1;
            state <= FINISH;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ds1302_time_set.sv
// ---------------------------------------------------------------------------
// tb_ds1302_time_set
//
// Self-checking bench for ds1302_time_set. A responder model answers each
// wrEn with a wrDone after a fixed or random delay (or never), a monitor
// logs every write, and each scenario task compares the logged traffic with
// a write list computed from the field values by plain decimal arithmetic.
// Honours DS1302_WP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ds1302_time_set;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] secIn = '0;
  logic [5:0] minIn = '0;
  logic [4:0] hourIn = '0;
  logic       wrDone = 1'b0;
  logic       wrEn;
  logic [7:0] wrAddr;
  logic [7:0] wrData;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor state (written only by the monitor; tasks snapshot it).
  logic [15:0] wrLog[$];
  int          wrCyc[$];
  int          dnCyc[$];
  int          doneCnt = 0;
  int          errCnt = 0;
  int          busyCnt = 0;
  int          holdBad = 0;

  // Responder control: respRand picks 1..TO per write, else respDelay
  // (0 means never answer).
  int respDelay = 10;
  bit respRand = 1'b0;

  logic [15:0] expQ[$];

  ds1302_time_set #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .secIn (secIn),
    .minIn (minIn),
    .hourIn(hourIn),
    .wrEn  (wrEn),
    .wrAddr(wrAddr),
    .wrData(wrData),
    .wrDone(wrDone),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wrEn) begin
      wrLog.push_back({wrAddr, wrData});
      wrCyc.push_back(cyc);
    end else if (busy && wrLog.size() > 0 && {wrAddr, wrData} !== wrLog[wrLog.size()-1]) begin
      holdBad++;
    end
    if (wrDone) dnCyc.push_back(cyc);
    if (done) doneCnt++;
    if (err) errCnt++;
    if (busy) busyCnt++;
  end

  initial begin : responder
    int d;
    forever begin
      @(negedge clk);
      if (wrEn && (respRand || respDelay > 0)) begin
        d = respRand ? int'($urandom_range(1, TO)) : respDelay;
        repeat (d) @(posedge clk);
        #1 wrDone = 1'b1;
        @(posedge clk);
        #1 wrDone = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  // Reference: decimal digits packed into nibbles.
  function automatic logic [7:0] bcdOf(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic buildExpected(input int s, input int m, input int h);
    expQ.delete();
`ifdef DS1302_WP_EN
    expQ.push_back(16'h8E00);
`endif
    expQ.push_back({8'h80, bcdOf(s)});
    expQ.push_back({8'h82, bcdOf(m)});
    expQ.push_back({8'h84, bcdOf(h)});
`ifdef DS1302_WP_EN
    expQ.push_back(16'h8E80);
`endif
  endtask

  // Drive one start, optionally a second start injAt iterations later, then
  // wait (bounded) for done or err. Inputs are scrambled after the start
  // cycle so a design that does not latch the request is exposed.
  task automatic runSeq(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                        input int injAt,
                        input logic [5:0] is, input logic [5:0] im, input logic [4:0] ih,
                        output logic b1, output logic w1, output logic e1,
                        output bit gotDone, output bit gotErr, output int endCyc,
                        output logic busyAfter);
    @(posedge clk);
    #1 secIn = s; minIn = m; hourIn = h; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    secIn = 6'($urandom_range(0, 63));
    minIn = 6'($urandom_range(0, 63));
    hourIn = 5'($urandom_range(0, 31));
    @(negedge clk);
    b1 = busy; w1 = wrEn; e1 = err;
    gotDone = 1'b0; gotErr = 1'b0; endCyc = -1;
    if (err) begin gotErr = 1'b1; endCyc = cyc; end
    for (int k = 0; k < 800 && !gotDone && !gotErr; k++) begin
      @(posedge clk);
      #1;
      if (k == injAt) begin
        secIn = is; minIn = im; hourIn = ih; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin gotDone = 1'b1; endCyc = cyc; end
      if (err) begin gotErr = 1'b1; endCyc = cyc; end
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    busyAfter = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wrEn !== 1'b0)    begin errors++; $display("FAIL reset_wrEn: got %b want 0", wrEn); end
    checks++; if (wrAddr !== 8'h00) begin errors++; $display("FAIL reset_wrAddr: got %h want 00", wrAddr); end
    checks++; if (wrData !== 8'h00) begin errors++; $display("FAIL reset_wrData: got %h want 00", wrData); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Full in-range sequence: write list, ordering, handshake timing, pulses.
  task automatic test_sequence(input int s, input int m, input int h, input int injAt);
    int w0, d0, dc0, ec0, hb0, n, endCyc;
    logic b1, w1, e1, busyAfter;
    bit gotDone, gotErr;
    logic [5:0] is, im;
    logic [4:0] ih;
    w0 = wrLog.size(); d0 = dnCyc.size(); dc0 = doneCnt; ec0 = errCnt; hb0 = holdBad;
    buildExpected(s, m, h);
    n = expQ.size();
    is = 6'((s + 17) % 60); im = 6'((m + 23) % 60); ih = 5'((h + 5) % 24);
    runSeq(6'(s), 6'(m), 5'(h), injAt, is, im, ih, b1, w1, e1, gotDone, gotErr, endCyc, busyAfter);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL seq_busy_rise: got %b want 1", b1); end
    checks++; if (w1 !== 1'b1) begin errors++; $display("FAIL seq_first_wrEn: got %b want 1", w1); end
    checks++; if (gotDone !== 1'b1) begin errors++; $display("FAIL seq_done_seen: got %b want 1", gotDone); end
    checks++; if (errCnt - ec0 != 0) begin errors++; $display("FAIL seq_no_err: got %0d want 0", errCnt - ec0); end
    checks++; if (doneCnt - dc0 != 1) begin errors++; $display("FAIL seq_done_count: got %0d want 1", doneCnt - dc0); end
    checks++; if (busyAfter !== 1'b0) begin errors++; $display("FAIL seq_busy_fall: got %b want 0", busyAfter); end
    checks++; if (holdBad != hb0) begin errors++; $display("FAIL seq_hold_stable: got %0d want %0d", holdBad, hb0); end
    checks++;
    if (wrLog.size() - w0 != n || dnCyc.size() - d0 != n) begin
      errors++;
      $display("FAIL seq_write_count: got %0d writes %0d acks want %0d", wrLog.size() - w0, dnCyc.size() - d0, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wrLog[w0+i] !== expQ[i]) begin
          errors++; $display("FAIL seq_write%0d: got %h want %h (time %0d:%0d:%0d)", i, wrLog[w0+i], expQ[i], h, m, s);
        end
        if (i < n - 1) begin
          checks++;
          if (wrCyc[w0+i+1] != dnCyc[d0+i] + 1) begin
            errors++; $display("FAIL seq_next_wrEn%0d: got cycle %0d want %0d", i, wrCyc[w0+i+1], dnCyc[d0+i] + 1);
          end
        end
      end
      checks++;
      if (endCyc != dnCyc[d0+n-1] + 1) begin
        errors++; $display("FAIL seq_done_timing: got cycle %0d want %0d", endCyc, dnCyc[d0+n-1] + 1);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_known_time;
    respRand = 1'b0; respDelay = 10;
`ifdef DS1302_WP_EN
    test_sequence(7, 45, 13, -1);
`else
    test_sequence(59, 59, 23, -1);
`endif
  endtask

  task automatic test_random_times;
    respRand = 1'b1;
    test_sequence(0, 0, 0, -1);
    test_sequence(59, 59, 23, -1);
    for (int i = 0; i < 6; i++)
      test_sequence(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)), int'($urandom_range(0, 23)), -1);
    respRand = 1'b0;
  endtask

  // wrDone arriving on the very cycle the wait counter hits its limit.
  task automatic test_done_at_limit;
    respRand = 1'b0; respDelay = TO;
    test_sequence(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)), int'($urandom_range(0, 23)), -1);
    respDelay = 10;
  endtask

  task automatic test_ignore_start;
    respRand = 1'b0; respDelay = 10;
    test_sequence(31, 8, 19, 5);
    respRand = 1'b1;
    test_sequence(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)), int'($urandom_range(0, 23)), 2);
    respRand = 1'b0;
  endtask

  task automatic test_range_reject(input int s, input int m, input int h);
    int w0, dc0, ec0, bc0, endCyc;
    logic b1, w1, e1, busyAfter;
    bit gotDone, gotErr;
    w0 = wrLog.size(); dc0 = doneCnt; ec0 = errCnt; bc0 = busyCnt;
    runSeq(6'(s), 6'(m), 5'(h), -1, 6'd0, 6'd0, 5'd0, b1, w1, e1, gotDone, gotErr, endCyc, busyAfter);
    repeat (4) @(negedge clk);
    checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL rej_err %0d:%0d:%0d: got %b want 1", h, m, s, e1); end
    checks++; if (w1 !== 1'b0) begin errors++; $display("FAIL rej_wrEn: got %b want 0", w1); end
    checks++; if (wrLog.size() != w0) begin errors++; $display("FAIL rej_no_write: got %0d want 0", wrLog.size() - w0); end
    checks++; if (busyCnt != bc0) begin errors++; $display("FAIL rej_busy: got %0d busy cycles want 0", busyCnt - bc0); end
    checks++; if (errCnt - ec0 != 1) begin errors++; $display("FAIL rej_err_pulse: got %0d want 1", errCnt - ec0); end
    checks++; if (doneCnt != dc0) begin errors++; $display("FAIL rej_no_done: got %0d want 0", doneCnt - dc0); end
  endtask

  task automatic test_timeout;
    int w0, dc0, ec0, endCyc, lat;
    logic b1, w1, e1, busyAfter;
    bit gotDone, gotErr;
    respRand = 1'b0; respDelay = 0;
    w0 = wrLog.size(); dc0 = doneCnt; ec0 = errCnt;
    runSeq(6'd12, 6'd34, 5'd5, -1, 6'd0, 6'd0, 5'd0, b1, w1, e1, gotDone, gotErr, endCyc, busyAfter);
    checks++; if (gotErr !== 1'b1) begin errors++; $display("FAIL to_err_seen: got %b want 1", gotErr); end
    checks++; if (busyAfter !== 1'b0) begin errors++; $display("FAIL to_busy_fall: got %b want 0", busyAfter); end
    repeat (2 * TO) @(negedge clk);
    checks++; if (wrLog.size() - w0 != 1) begin errors++; $display("FAIL to_write_count: got %0d want 1", wrLog.size() - w0); end
    checks++; if (doneCnt != dc0) begin errors++; $display("FAIL to_no_done: got %0d want 0", doneCnt - dc0); end
    checks++; if (errCnt - ec0 != 1) begin errors++; $display("FAIL to_err_pulse: got %0d want 1", errCnt - ec0); end
    if (wrLog.size() > w0) begin
      lat = endCyc - wrCyc[w0];
      checks++;
      if (lat < TO || lat > TO + 1) begin
        errors++; $display("FAIL to_latency: got %0d cycles want %0d..%0d", lat, TO, TO + 1);
      end
    end
    respDelay = 10;
  endtask

  task automatic test_rst_mid;
    int w0, dc0;
    bit reached;
    respRand = 1'b0; respDelay = 10;
    w0 = wrLog.size(); dc0 = doneCnt;
    @(posedge clk);
    #1 secIn = 6'd44; minIn = 6'd21; hourIn = 5'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 300 && !reached; k++) begin
      @(negedge clk);
      if (wrLog.size() >= w0 + 3) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL rst_reach_step2: got %0d writes want 3", wrLog.size() - w0); end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (wrEn !== 1'b0)    begin errors++; $display("FAIL rst_wrEn: got %b want 0", wrEn); end
    checks++; if (wrAddr !== 8'h00) begin errors++; $display("FAIL rst_wrAddr: got %h want 00", wrAddr); end
    checks++; if (wrData !== 8'h00) begin errors++; $display("FAIL rst_wrData: got %h want 00", wrData); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    repeat (30) @(negedge clk);
    checks++; if (wrLog.size() - w0 != 3) begin errors++; $display("FAIL rst_no_more_writes: got %0d want 3", wrLog.size() - w0); end
    checks++; if (doneCnt != dc0) begin errors++; $display("FAIL rst_no_done: got %0d want 0", doneCnt - dc0); end
    // A fresh start after the reset must run the whole table from step 0.
    test_sequence(3, 14, 15, -1);
  endtask

  initial begin
    test_reset();
    test_known_time();
    test_random_times();
    test_done_at_limit();
    test_ignore_start();
    test_range_reject(60, 10, 10);
    test_range_reject(10, 60, 10);
    test_range_reject(10, 10, 24);
    test_range_reject(int'($urandom_range(60, 63)), int'($urandom_range(0, 63)), int'($urandom_range(0, 31)));
    test_timeout();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ds1302_time_set.md
# ds1302_time_set

Time-set sequencer for the DS1302 RTC path. Accepts a binary hour/minute/second triple on a start pulse, range-checks it, converts each field to BCD, and issues an ordered burst of single-byte register writes to the downstream 1-byte write engine over its `en`/`addr`/`dataIn`/`done` handshake. It sits directly upstream of the write engine, between the user-facing time-edit logic (rotary encoder UI) and the serial RTC write stage.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 2_000_000: max `clk` cycles to wait for `wrDone` per write before aborting.

Ports:
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to write the time; sampled only in IDLE.
- `secIn` input 6: seconds, binary, valid 0..59.
- `minIn` input 6: minutes, binary, valid 0..59.
- `hourIn` input 5: hours, binary, 24 h, valid 0..23.
- `wrEn` output 1: one-cycle write request to the write engine.
- `wrAddr` output 8: DS1302 write command byte.
- `wrData` output 8: byte to write.
- `wrDone` input 1: one-cycle completion pulse from the write engine.
- `busy` output 1: high from the cycle after an accepted `start` until the sequence ends.
- `done` output 1: one-cycle pulse when all writes have completed.
- `err` output 1: one-cycle pulse on a range reject or timeout.

## Operation
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - `start`=1 with all fields in range: latch BCD-converted fields, set step index 0, go to ISSUE.
  - `start`=1 with any field out of range (sec>59, min>59, hour>23): pulse `err`, stay IDLE, issue no write.
- BCD conversion: tens = v/10 by compare-subtract; ones = v − 10·tens. Result byte = {tens, ones}.
  - Seconds bit 7 (CH) = 0, so the clock runs.
  - Hours bit 7 = 0 (24 h mode); bits 5:4 = tens.
- Step table with `DS1302_WP_EN` defined, 5 steps:
  - 0x8E←0x00 (clear write-protect)
  - 0x80←sec
  - 0x82←min
  - 0x84←hour
  - 0x8E←0x80 (set write-protect)
- Step table without `DS1302_WP_EN`: 3 steps, 0x80, 0x82, 0x84 only.
- ISSUE: drive `wrAddr`/`wrData` for the current step, `wrEn`=1 for exactly one cycle, go to WAIT. Clear the timeout counter.
- WAIT:
  - Hold `wrAddr`/`wrData` stable.
  - On `wrDone`: if last step, go to FINISH; else increment step and go to ISSUE.
  - Timeout counter reaches `TIMEOUT_CYCLES`−1 without `wrDone`: pulse `err`, go to IDLE. Remaining steps are not issued.
- FINISH: pulse `done`, go to IDLE.
- `start` while `busy` is ignored; latched fields never change mid-sequence.
- `wrDone` seen in IDLE or ISSUE is ignored.

## Timing
- Reset values: `wrEn`=0, `wrAddr`=0x00, `wrData`=0x00, `busy`=0, `done`=0, `err`=0; state IDLE, step 0, timeout counter 0.
- `start` accepted at cycle N: `busy`=1 and `wrEn`=1 at N+1.
- `wrDone` at cycle M (not the last step): next `wrEn` at M+1.
- `wrDone` on the last step at cycle M: `done`=1 at M+1; `busy`=0 at M+2.
- Range reject: `err`=1 at N+1; `busy` never rises.
- Timeout: `err`=1 the cycle after the counter hits its limit; `busy`=0 the following cycle.
- `wrDone` in the same cycle as the timeout limit: `wrDone` wins and the sequence proceeds.
- `rst` mid-sequence: all outputs return to reset values at the next edge; no further `wrEn`. The downstream engine may finish its current byte.
- `done` and `err` are never high in the same cycle.

## Configuration
- `DS1302_WP_EN` defined: 5-step sequence; write-protect is cleared before the time registers and set afterwards.
- `DS1302_WP_EN` undefined: 3-step sequence. The WP register is never touched, and the caller is responsible for write-protect.

## Test plan
- With `DS1302_WP_EN`, `start` with 13:45:07, model answers `wrDone` 10 cycles after each `wrEn` -> writes (0x8E,0x00), (0x80,0x07), (0x82,0x45), (0x84,0x13), (0x8E,0x80) in order; single `done` pulse; `busy` low after.
- Without `DS1302_WP_EN`, `start` with 23:59:59 -> exactly three writes (0x80,0x59), (0x82,0x59), (0x84,0x23); `done` one cycle after the third `wrDone`.
- `start` with `minIn`=60 -> `err`=1 next cycle; no `wrEn`; `busy` stays 0.
- `TIMEOUT_CYCLES`=16, model never asserts `wrDone` -> one `wrEn`, `err` pulse 16–17 cycles later, FSM back in IDLE, no `done`.
- Second `start` with different values during the sequence -> ignored; written bytes match the first request.
- `rst` asserted in WAIT of step 2 -> next cycle all outputs are 0; a subsequent `start` restarts from step 0.
